gemm_tile_scheduler: RTL and testbench
======================================

// Module: gemm_tile_scheduler
// PURPOSE
//  Ping-pong scheduler between the host job path and the dispatcher/compute pair.
//  Splits the dispatcher BRAM into two buffers. It fetches job N+1 (left then right
//  matrix) into one buffer while the compute engine consumes job N from the other.
//  Sits between master_control-side job issue and the dispatcher_control fetch /
//  compute-engine tile handshakes. Jobs complete in issue order.
// PARAMETERS
//  ADDR_W      25    DDR line address width (fetch addr)
//  LEN_W       12    line-count width (fetch len)
//  TILE_ADDR_W 11    BRAM line address width
//  BUF_LINES   1024  lines per ping-pong buffer (buffer b base = b*BUF_LINES)
// PORTS
//  i_clk              in   1            clock
//  i_reset_n          in   1            sync reset, active low
//  i_job_valid        in   1            job descriptor valid
//  o_job_ready        out  1            job accepted when valid&ready
//  i_job_left_addr    in   ADDR_W       DDR line addr of left matrix
//  i_job_right_addr   in   ADDR_W       DDR line addr of right matrix
//  i_job_len          in   LEN_W        lines per matrix (L)
//  o_fetch_en         out  1            1-cycle fetch request pulse to dispatcher
//  o_fetch_addr       out  ADDR_W       DDR line addr for fetch
//  o_fetch_len        out  LEN_W        lines to fetch
//  o_fetch_bram_base  out  TILE_ADDR_W  BRAM write base for fetch
//  i_fetch_done       in   1            1-cycle pulse, fetch complete
//  o_tile_en          out  1            1-cycle tile start pulse to compute engine
//  o_tile_left_addr   out  TILE_ADDR_W  BRAM base of left matrix
//  o_tile_right_addr  out  TILE_ADDR_W  BRAM base of right matrix
//  i_tile_done        in   1            1-cycle pulse, tile complete
//  o_busy             out  1            any buffer not FREE or any FSM not idle
//  o_jobs_done        out  16           completed tile count, wraps at 2^16
//  o_err              out  1            sticky error flag
//  o_state            out  4            {fetch_state[2:0], compute_busy}
// BEHAVIOUR
//  - Reset: all outputs 0; both buffers FREE; fill_ptr=cmp_ptr=0; FSMs idle.
//    Reset mid-operation abandons in-flight jobs; done pulses then arrive in idle
//    and follow the unexpected-done rule below.
//  - Buffer state per buffer b: FREE -> FILLING -> FULL -> COMPUTING -> FREE.
//  - o_job_ready = (fetch FSM in F_IDLE) & (buf[fill_ptr]==FREE).
//  - Job rejection: L==0 or 2*L > BUF_LINES.
//    * Job is accepted (consumes the handshake) but dropped.
//    * o_err is set; no fetch is issued; fill_ptr is unchanged.
//  - Fetch FSM: F_IDLE -> F_LEFT -> F_WAIT_L -> F_RIGHT -> F_WAIT_R -> F_IDLE.
//    * Accept at cycle T: buf[fill_ptr]=FILLING and descriptor latched.
//    * T+1: o_fetch_en=1, addr=left, len=L, base=fill_ptr*BUF_LINES.
//    * i_fetch_done at T': at T'+1 o_fetch_en=1, addr=right, len=L,
//      base=fill_ptr*BUF_LINES+L.
//    * Second i_fetch_done at T'': buf=FULL at T''+1; fill_ptr toggles; F_IDLE.
//  - Compute FSM: C_IDLE -> C_RUN -> C_WAIT -> C_IDLE.
//    * In C_IDLE with buf[cmp_ptr]==FULL: next cycle o_tile_en=1 for one cycle.
//    * Tile addrs: left = cmp_ptr*BUF_LINES, right = left+L (L latched per buffer).
//    * Buffer goes COMPUTING at the o_tile_en cycle.
//    * i_tile_done in C_WAIT: buffer FREE next cycle; cmp_ptr toggles; o_jobs_done++.
//  - Minimum latency: second fetch_done at T -> o_tile_en at T+2.
//  - Freed buffer: o_job_ready may rise the cycle after the FREE update (registered).
//  - Simultaneous i_fetch_done and i_tile_done: both processed the same cycle.
//    Each affects only its own buffer, so they never conflict.
//  - Unexpected done: i_fetch_done outside F_WAIT_*, or i_tile_done outside C_WAIT.
//    The pulse is ignored and o_err is set.
//  - o_fetch_* and o_tile_*_addr hold their last value between pulses.
//  - o_err clears only on reset.
// TESTING
//  1. Single job (left=0x100, right=0x200, L=16).
//     - fetch pulses: (0x100,16,base 0), then (0x200,16,base 16).
//     - o_tile_en with left=0, right=16.
//     - After tile_done: o_jobs_done=1, o_busy=0.
//  2. Two back-to-back jobs, L=32.
//     - Job 2 fetches into base 1024/1056 while tile 1 computes.
//     - tile 2 addrs are 1024/1056; the two tiles run in order.
//  3. Three queued jobs with tile 1 held off.
//     - o_job_ready stays 0 after job 2 fills.
//     - Rises the cycle after buffer 0 is freed by tile_done.
//  4. Rejected lengths: L=513 and L=0.
//     - Each job is accepted, o_err=1, no o_fetch_en, fill_ptr unchanged.
//     - A following valid job runs normally.
//  5. Concurrent events: right fetch_done of job 2 in the same cycle as tile_done of job 1.
//     - Both buffers update correctly.
//     - o_tile_en for job 2 exactly 2 cycles later.
//  6. Reset asserted in F_WAIT_L; later a stray i_fetch_done.
//     - All outputs 0 after reset.
//     - The stray i_fetch_done sets o_err; no fetch is issued.

Source files
------------

// File: rtl/gemm_tile_scheduler.sv
// Ping-pong tile scheduler: fills one BRAM half with job N+1 (left, then right matrix)
// while the compute engine consumes job N from the other half; jobs retire in issue order.
module gemm_tile_scheduler #(
    parameter int ADDR_W      = 25,
    parameter int LEN_W       = 12,
    parameter int TILE_ADDR_W = 11,
    parameter int BUF_LINES   = 1024
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_job_valid,
    output logic                   o_job_ready,
    input  logic [ADDR_W-1:0]      i_job_left_addr,
    input  logic [ADDR_W-1:0]      i_job_right_addr,
    input  logic [LEN_W-1:0]       i_job_len,
    output logic                   o_fetch_en,
    output logic [ADDR_W-1:0]      o_fetch_addr,
    output logic [LEN_W-1:0]       o_fetch_len,
    output logic [TILE_ADDR_W-1:0] o_fetch_bram_base,
    input  logic                   i_fetch_done,
    output logic                   o_tile_en,
    output logic [TILE_ADDR_W-1:0] o_tile_left_addr,
    output logic [TILE_ADDR_W-1:0] o_tile_right_addr,
    input  logic                   i_tile_done,
    output logic                   o_busy,
    output logic [15:0]            o_jobs_done,
    output logic                   o_err,
    output logic [3:0]             o_state
);

    typedef enum logic [2:0] {
        F_IDLE   = 3'd0,
        F_LEFT   = 3'd1,
        F_WAIT_L = 3'd2,
        F_RIGHT  = 3'd3,
        F_WAIT_R = 3'd4
    } fetch_state_t;

    typedef enum logic [1:0] {C_IDLE, C_RUN, C_WAIT} cmp_state_t;

    typedef enum logic [1:0] {B_FREE, B_FILLING, B_FULL, B_COMPUTING} buf_state_t;

    localparam logic [TILE_ADDR_W-1:0] BASE1   = TILE_ADDR_W'(BUF_LINES);
    localparam logic [LEN_W:0]         MAX_DBL = (LEN_W+1)'(BUF_LINES);

    fetch_state_t           fstate_q;
    cmp_state_t             cstate_q;
    buf_state_t             buf_q  [2];
    logic [LEN_W-1:0]       blen_q [2];
    logic                   fill_ptr_q;
    logic                   cmp_ptr_q;
    logic                   job_ready_q;
    logic                   fetch_en_q;
    logic [ADDR_W-1:0]      fetch_addr_q;
    logic [ADDR_W-1:0]      right_addr_q;
    logic [LEN_W-1:0]       fetch_len_q;
    logic [TILE_ADDR_W-1:0] fetch_base_q;
    logic                   tile_en_q;
    logic [TILE_ADDR_W-1:0] tile_left_q;
    logic [TILE_ADDR_W-1:0] tile_right_q;
    logic [15:0]            jobs_done_q;
    logic                   err_q;

    logic                   accept;
    logic                   len_ok;
    logic [LEN_W:0]         dbl_len;
    logic                   fill_start;
    logic                   fill_done;
    logic                   cmp_start;
    logic                   cmp_done;
    logic                   stray_fetch;
    logic                   stray_tile;
    logic [TILE_ADDR_W-1:0] cmp_base;

    assign dbl_len     = {i_job_len, 1'b0};
    assign len_ok      = (i_job_len != '0) && (dbl_len <= MAX_DBL);
    assign accept      = i_job_valid && job_ready_q;
    assign fill_start  = accept && len_ok;
    assign fill_done   = (fstate_q == F_WAIT_R) && i_fetch_done;
    assign cmp_start   = (cstate_q == C_IDLE) && (buf_q[cmp_ptr_q] == B_FULL);
    assign cmp_done    = (cstate_q == C_WAIT) && i_tile_done;
    assign stray_fetch = i_fetch_done && (fstate_q != F_WAIT_L) && (fstate_q != F_WAIT_R);
    assign stray_tile  = i_tile_done && (cstate_q != C_WAIT);
    assign cmp_base    = cmp_ptr_q ? BASE1 : '0;

    // Each event only ever touches the buffer its own pointer selects, and the
    // buffer states they require are disjoint, so at most one branch fires per buffer.
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 2; b++) begin
            if (!i_reset_n) begin
                buf_q[b]  <= B_FREE;
                blen_q[b] <= '0;
            end else if (fill_start && fill_ptr_q == 1'(b)) begin
                buf_q[b]  <= B_FILLING;
                blen_q[b] <= i_job_len;
            end else if (fill_done && fill_ptr_q == 1'(b)) begin
                buf_q[b] <= B_FULL;
            end else if (cmp_start && cmp_ptr_q == 1'(b)) begin
                buf_q[b] <= B_COMPUTING;
            end else if (cmp_done && cmp_ptr_q == 1'(b)) begin
                buf_q[b] <= B_FREE;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            fstate_q     <= F_IDLE;
            fill_ptr_q   <= 1'b0;
            job_ready_q  <= 1'b0;
            fetch_en_q   <= 1'b0;
            fetch_addr_q <= '0;
            right_addr_q <= '0;
            fetch_len_q  <= '0;
            fetch_base_q <= '0;
        end else begin
            fetch_en_q  <= 1'b0;
            // Ready is registered from the current state; masking with accept keeps it
            // from staying high for a second handshake in the cycle after a take.
            job_ready_q <= (fstate_q == F_IDLE) && (buf_q[fill_ptr_q] == B_FREE) && !accept;
            case (fstate_q)
                F_IDLE: if (fill_start) begin
                    fstate_q     <= F_LEFT;
                    fetch_en_q   <= 1'b1;
                    fetch_addr_q <= i_job_left_addr;
                    fetch_len_q  <= i_job_len;
                    fetch_base_q <= fill_ptr_q ? BASE1 : '0;
                    right_addr_q <= i_job_right_addr;
                end
                F_LEFT: fstate_q <= F_WAIT_L;
                F_WAIT_L: if (i_fetch_done) begin
                    fstate_q     <= F_RIGHT;
                    fetch_en_q   <= 1'b1;
                    fetch_addr_q <= right_addr_q;
                    fetch_base_q <= fetch_base_q + TILE_ADDR_W'(fetch_len_q);
                end
                F_RIGHT: fstate_q <= F_WAIT_R;
                F_WAIT_R: if (i_fetch_done) begin
                    fstate_q   <= F_IDLE;
                    fill_ptr_q <= ~fill_ptr_q;
                end
                default: fstate_q <= F_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            cstate_q     <= C_IDLE;
            cmp_ptr_q    <= 1'b0;
            tile_en_q    <= 1'b0;
            tile_left_q  <= '0;
            tile_right_q <= '0;
            jobs_done_q  <= '0;
        end else begin
            tile_en_q <= 1'b0;
            case (cstate_q)
                C_IDLE: if (cmp_start) begin
                    cstate_q     <= C_RUN;
                    tile_en_q    <= 1'b1;
                    tile_left_q  <= cmp_base;
                    tile_right_q <= cmp_base + TILE_ADDR_W'(blen_q[cmp_ptr_q]);
                end
                C_RUN: cstate_q <= C_WAIT;
                C_WAIT: if (i_tile_done) begin
                    cstate_q    <= C_IDLE;
                    cmp_ptr_q   <= ~cmp_ptr_q;
                    jobs_done_q <= jobs_done_q + 16'd1;
                end
                default: cstate_q <= C_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            err_q <= 1'b0;
        end else if ((accept && !len_ok) || stray_fetch || stray_tile) begin
            err_q <= 1'b1;
        end
    end

    assign o_job_ready       = job_ready_q;
    assign o_fetch_en        = fetch_en_q;
    assign o_fetch_addr      = fetch_addr_q;
    assign o_fetch_len       = fetch_len_q;
    assign o_fetch_bram_base = fetch_base_q;
    assign o_tile_en         = tile_en_q;
    assign o_tile_left_addr  = tile_left_q;
    assign o_tile_right_addr = tile_right_q;
    assign o_jobs_done       = jobs_done_q;
    assign o_err             = err_q;
    assign o_busy            = (fstate_q != F_IDLE) || (cstate_q != C_IDLE) ||
                               (buf_q[0] != B_FREE) || (buf_q[1] != B_FREE);
    assign o_state           = {fstate_q, cstate_q != C_IDLE};

endmodule

// File: tb/tb_gemm_tile_scheduler.sv
// Directed bench for gemm_tile_scheduler: expected fetch/tile transactions are queued
// as jobs are issued and checked by a monitor as the scheduler emits them.
module tb_gemm_tile_scheduler;

    localparam int ADDR_W    = 25;
    localparam int LEN_W     = 12;
    localparam int TW        = 11;
    localparam int BUF_LINES = 1024;

    logic              clk = 1'b0;
    logic              i_reset_n = 1'b0;
    logic              i_job_valid = 1'b0;
    logic              o_job_ready;
    logic [ADDR_W-1:0] i_job_left_addr = '0;
    logic [ADDR_W-1:0] i_job_right_addr = '0;
    logic [LEN_W-1:0]  i_job_len = '0;
    logic              o_fetch_en;
    logic [ADDR_W-1:0] o_fetch_addr;
    logic [LEN_W-1:0]  o_fetch_len;
    logic [TW-1:0]     o_fetch_bram_base;
    logic              i_fetch_done = 1'b0;
    logic              o_tile_en;
    logic [TW-1:0]     o_tile_left_addr;
    logic [TW-1:0]     o_tile_right_addr;
    logic              i_tile_done = 1'b0;
    logic              o_busy;
    logic [15:0]       o_jobs_done;
    logic              o_err;
    logic [3:0]        o_state;

    always #5 clk = ~clk;

    gemm_tile_scheduler #(
        .ADDR_W(ADDR_W), .LEN_W(LEN_W), .TILE_ADDR_W(TW), .BUF_LINES(BUF_LINES)
    ) dut (
        .i_clk(clk),
        .i_reset_n(i_reset_n),
        .i_job_valid(i_job_valid),
        .o_job_ready(o_job_ready),
        .i_job_left_addr(i_job_left_addr),
        .i_job_right_addr(i_job_right_addr),
        .i_job_len(i_job_len),
        .o_fetch_en(o_fetch_en),
        .o_fetch_addr(o_fetch_addr),
        .o_fetch_len(o_fetch_len),
        .o_fetch_bram_base(o_fetch_bram_base),
        .i_fetch_done(i_fetch_done),
        .o_tile_en(o_tile_en),
        .o_tile_left_addr(o_tile_left_addr),
        .o_tile_right_addr(o_tile_right_addr),
        .i_tile_done(i_tile_done),
        .o_busy(o_busy),
        .o_jobs_done(o_jobs_done),
        .o_err(o_err),
        .o_state(o_state)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [ADDR_W+LEN_W+TW-1:0] fetch_q [$];
    logic [2*TW-1:0]            tile_q  [$];
    logic                       fill_ptr_m = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every fetch/tile pulse is one transaction matched against the scoreboard.
    always @(negedge clk) begin
        if (o_fetch_en) begin
            if (fetch_q.size() == 0) begin
                chk("fetch_unexpected", 64'd1, 64'd0);
            end else begin
                logic [ADDR_W+LEN_W+TW-1:0] fe;
                fe = fetch_q.pop_front();
                chk("fetch_txn", {o_fetch_addr, o_fetch_len, o_fetch_bram_base}, fe);
                $display("fetch addr=0x%0h len=%0d base=%0d", o_fetch_addr, o_fetch_len, o_fetch_bram_base);
            end
        end
        if (o_tile_en) begin
            if (tile_q.size() == 0) begin
                chk("tile_unexpected", 64'd1, 64'd0);
            end else begin
                logic [2*TW-1:0] te;
                te = tile_q.pop_front();
                chk("tile_txn", {o_tile_left_addr, o_tile_right_addr}, te);
                $display("tile left=%0d right=%0d", o_tile_left_addr, o_tile_right_addr);
            end
        end
    end

    task automatic send_job(input logic [ADDR_W-1:0] l, input logic [ADDR_W-1:0] r,
                            input logic [LEN_W-1:0] len, input bit push);
        int k = 0;
        logic [TW-1:0] base;
        while (!o_job_ready && k < 200) begin tick(1); k++; end
        chk("job_ready_timeout", o_job_ready, 1);
        if (push && len != 0 && 2 * int'(len) <= BUF_LINES) begin
            base = fill_ptr_m ? TW'(BUF_LINES) : TW'(0);
            fetch_q.push_back({l, len, base});
            fetch_q.push_back({r, len, base + TW'(len)});
            tile_q.push_back({base, base + TW'(len)});
            fill_ptr_m = ~fill_ptr_m;
        end
        i_job_valid      = 1'b1;
        i_job_left_addr  = l;
        i_job_right_addr = r;
        i_job_len        = len;
        tick(1);
        i_job_valid = 1'b0;
        $display("job left=0x%0h right=0x%0h len=%0d", l, r, len);
    endtask

    task automatic wait_fetch();
        int k = 0;
        while (!o_fetch_en && k < 200) begin tick(1); k++; end
        chk("fetch_timeout", o_fetch_en, 1);
    endtask

    task automatic wait_tile();
        int k = 0;
        while (!o_tile_en && k < 200) begin tick(1); k++; end
        chk("tile_timeout", o_tile_en, 1);
    endtask

    task automatic fetch_ack();
        tick(1);
        i_fetch_done = 1'b1;
        tick(1);
        i_fetch_done = 1'b0;
    endtask

    task automatic tile_ack();
        tick(1);
        i_tile_done = 1'b1;
        tick(1);
        i_tile_done = 1'b0;
    endtask

    task automatic fill_job();
        wait_fetch(); fetch_ack();
        wait_fetch(); fetch_ack();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_a"}, {o_job_ready, o_fetch_en, o_fetch_addr, o_fetch_len, o_fetch_bram_base}, 0);
        chk({tag, "_b"}, {o_tile_en, o_tile_left_addr, o_tile_right_addr, o_busy,
                          o_jobs_done, o_err, o_state}, 0);
    endtask

    task automatic do_reset();
        i_reset_n = 1'b0;
        tick(2);
        fill_ptr_m = 1'b0;
        i_reset_n = 1'b1;
        tick(1);
    endtask

    initial begin
        // 1: single job
        tick(3);
        chk_zero("reset_state");
        i_reset_n = 1'b1;
        tick(1);
        chk("ready_after_reset", o_job_ready, 1);
        send_job(25'h100, 25'h200, 12'd16, 1);
        fill_job();
        wait_tile();
        tile_ack();
        chk("t1_jobs_done", o_jobs_done, 1);
        chk("t1_busy", o_busy, 0);
        chk("t1_err", o_err, 0);

        // 2: two back-to-back jobs, second fills while first computes
        do_reset();
        send_job(25'h1000, 25'h2000, 12'd32, 1);
        fill_job();
        wait_tile();
        send_job(25'h3000, 25'h4000, 12'd32, 1);
        fill_job();
        chk("t2_compute_busy", o_state[0], 1);
        tile_ack();
        wait_tile();
        tile_ack();
        chk("t2_jobs_done", o_jobs_done, 2);

        // 3: both buffers occupied, ready held low until buffer 0 frees
        do_reset();
        send_job(25'h10, 25'h20, 12'd8, 1);
        fill_job();
        wait_tile();
        send_job(25'h30, 25'h40, 12'd8, 1);
        fill_job();
        tick(3);
        chk("t3_ready_held", o_job_ready, 0);
        tile_ack();
        chk("t3_ready_free_cycle", o_job_ready, 0);
        tick(1);
        chk("t3_ready_rise", o_job_ready, 1);
        send_job(25'h50, 25'h60, 12'd8, 1);
        fill_job();
        tile_ack();
        wait_tile();
        tile_ack();
        chk("t3_jobs_done", o_jobs_done, 3);

        // 4: rejected lengths
        do_reset();
        send_job(25'h700, 25'h800, 12'd513, 1);
        chk("t4_err_513", o_err, 1);
        chk("t4_no_fetch_513", o_fetch_en, 0);
        tick(2);
        chk("t4_idle_513", o_state, 0);
        send_job(25'h700, 25'h800, 12'd0, 1);
        tick(2);
        chk("t4_idle_0", o_state, 0);
        send_job(25'h300, 25'h380, 12'd512, 1);
        fill_job();
        wait_tile();
        tile_ack();
        chk("t4_jobs_done", o_jobs_done, 1);
        chk("t4_err_sticky", o_err, 1);

        // 5: right fetch_done of job 2 coincides with tile_done of job 1
        do_reset();
        send_job(25'h900, 25'hA00, 12'd16, 1);
        fill_job();
        wait_tile();
        send_job(25'hB00, 25'hC00, 12'd16, 1);
        wait_fetch(); fetch_ack();
        wait_fetch();
        tick(1);
        i_fetch_done = 1'b1;
        i_tile_done  = 1'b1;
        tick(1);
        i_fetch_done = 1'b0;
        i_tile_done  = 1'b0;
        chk("t5_jobs_done_1", o_jobs_done, 1);
        chk("t5_tile_not_yet", o_tile_en, 0);
        tick(1);
        chk("t5_tile_at_2", o_tile_en, 1);
        chk("t5_err", o_err, 0);
        tile_ack();
        chk("t5_jobs_done_2", o_jobs_done, 2);
        chk("t5_busy", o_busy, 0);

        // 6: reset while waiting for the left fetch, then a stray fetch_done
        do_reset();
        fetch_q.push_back({25'h1234, 12'd4, 11'd0});
        send_job(25'h1234, 25'h5678, 12'd4, 0);
        wait_fetch();
        tick(1);
        chk("t6_in_wait_l", o_state[3:1], 3'd2);
        i_reset_n = 1'b0;
        tick(1);
        chk_zero("t6_reset");
        i_reset_n = 1'b1;
        tick(2);
        i_fetch_done = 1'b1;
        tick(1);
        i_fetch_done = 1'b0;
        tick(3);
        chk("t6_err", o_err, 1);
        chk("t6_no_fetch", o_fetch_en, 0);
        chk("t6_idle", o_state, 0);

        chk("fetch_queue_empty", fetch_q.size(), 0);
        chk("tile_queue_empty", tile_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=completion");
        $fatal(1, "watchdog");
    end

endmodule
